ibex_instr_bus_arbiter: RTL and testbench
=========================================

# ibex_instr_bus_arbiter

Two-requester arbiter for the single instruction memory port. Requester 0 is the prefetch buffer; requester 1 is a secondary instruction-side master such as a debug-module fetch or a memory-scrubber read. The block sits between those masters and the external instruction bus. It keeps each bus request stable until it is granted, tracks the owner of every outstanding transaction in order, and routes each rvalid, rdata and err back to the requester that issued it.

## Interface
Parameters:
- MaxOutstanding, 2, maximum granted-but-unanswered bus transactions; legal range 1..4.
- RoundRobin, 1'b1, 1 selects alternating priority on contention; 0 gives requester 0 fixed priority.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- r0_req_i  in  1  requester 0 request; held with its address until r0_gnt_o.
- r0_addr_i  in  32  requester 0 word address.
- r0_gnt_o  out  1  requester 0 request accepted by the bus this cycle.
- r0_rvalid_o  out  1  response for requester 0.
- r0_err_o  out  1  bus error qualifying r0_rvalid_o.
- r1_req_i, r1_addr_i, r1_gnt_o, r1_rvalid_o, r1_err_o  same as above, for requester 1.
- rdata_o  out  32  instr_rdata_i passthrough, shared by both requesters.
- instr_req_o  out  1  bus request.
- instr_addr_o  out  32  bus address; bits [1:0] are forced to 0.
- instr_gnt_i  in  1  bus grant.
- instr_rvalid_i  in  1  bus response valid.
- instr_rdata_i  in  32  bus read data.
- instr_err_i  in  1  bus error, valid with instr_rvalid_i.
- busy_o  out  1  high while any transaction is outstanding or instr_req_o is high.
- spurious_o  out  1  single-cycle pulse when instr_rvalid_i arrives and no transaction is outstanding.

## Operation
- States:
  - IDLE: no ungranted request on the bus.
  - LOCK0: requester 0's ungranted request is being held on the bus.
  - LOCK1: same, for requester 1.
- Issue condition: count < MaxOutstanding. Requests while count == MaxOutstanding are ignored, with no grant and no bypass, even if instr_rvalid_i is high that cycle.
- Selection in IDLE:
  - Only one requester active: that requester is selected.
  - Both active with RoundRobin=1: the requester other than last_q is selected.
  - Both active with RoundRobin=0: requester 0 is selected.
- A selected request drives instr_req_o=1 and instr_addr_o = the selected address with [1:0] zeroed.
- Selected and not granted: go to LOCKn. While in LOCKn, arbitration is frozen and only requester n drives the bus, so address stability is guaranteed.
- Granted, whether from IDLE or LOCKn:
  - rn_gnt_o=1 in the same cycle, combinationally from instr_gnt_i.
  - Push owner n into the owner FIFO (depth MaxOutstanding).
  - Set last_q=n and go to IDLE.
- A requester dropping req while in LOCKn is a protocol violation. The arbiter keeps instr_req_o high with the held address and stays in LOCKn until granted; the grant is still reported as rn_gnt_o.
- Response routing on instr_rvalid_i with the FIFO non-empty:
  - Pop the head and pulse r<head>_rvalid_o.
  - r<head>_err_o = instr_err_i.
  - The other requester's rvalid_o stays 0.
- instr_rvalid_i with the FIFO empty: drop the response and pulse spurious_o.
- Grant and rvalid in the same cycle: push and pop occur together and count is unchanged.
- count is a ceil(log2(MaxOutstanding+1))-bit counter equal to the FIFO occupancy. It never exceeds MaxOutstanding and never goes below 0.

## Timing
- Reset values: state=IDLE, count=0, FIFO empty, last_q=1 (requester 0 wins the first contention).
- Output values during and immediately after reset: instr_req_o=0, all gnt_o=0, all rvalid_o=0, all err_o=0, busy_o=0, spurious_o=0.
- Reset asserted mid-transaction: outstanding ownership is discarded. Bus responses arriving after reset are dropped with spurious_o pulses.
- Request path: req to instr_req_o is zero-cycle (combinational) in IDLE.
- Grant path: instr_gnt_i to rn_gnt_o is zero-cycle.
- Response path: instr_rvalid_i to rn_rvalid_o is zero-cycle; rdata_o is a pure wire.
- Issue rate: one granted request per cycle maximum. Back-to-back grants to alternating requesters are allowed.
- The owner FIFO, state and last_q update at the clock edge after the cycle in which the event occurs.

## Test plan
- Single-requester stream: r0 requests 0x100, 0x104, 0x108 with instr_gnt_i always 1 and rvalid one cycle later -> three r0_gnt_o, three r0_rvalid_o in order, r1 outputs stay 0.
- Lock on stall: r0 requests 0x200 with gnt low for 3 cycles while r1 requests 0x300 -> instr_addr_o stays 0x200 for 4 cycles; r1 is granted in the cycle after the r0 grant.
- Round robin: both requesters continuously active, 6 grants -> grant order r0,r1,r0,r1,r0,r1; with RoundRobin=0 the order is six r0 grants.
- Outstanding limit: MaxOutstanding=2, two grants issued, rvalid withheld -> instr_req_o=0 until the first rvalid. A third request is then granted and response owners match issue order, including an r1/r0 interleave.
- Error and spurious: rvalid with instr_err_i=1 on an r1-owned transaction -> r1_rvalid_o=1, r1_err_o=1. A later rvalid with the FIFO empty -> spurious_o=1 for one cycle and no rvalid_o.
- Async reset while count=2 and in LOCK1 -> outputs are 0 immediately. The next two rvalids each pulse spurious_o, and the first request after reset is granted normally.

Source files
------------

// File: rtl/ibex_instr_bus_arbiter.sv
// Two-requester arbiter for the instruction bus: holds an ungranted request stable,
// records the owner of every outstanding transaction in order and routes responses back.
module ibex_instr_bus_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          RoundRobin     = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        r0_req_i,
    input  logic [31:0] r0_addr_i,
    output logic        r0_gnt_o,
    output logic        r0_rvalid_o,
    output logic        r0_err_o,

    input  logic        r1_req_i,
    input  logic [31:0] r1_addr_i,
    output logic        r1_gnt_o,
    output logic        r1_rvalid_o,
    output logic        r1_err_o,

    output logic [31:0] rdata_o,

    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,

    output logic        busy_o,
    output logic        spurious_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOCK0,
        LOCK1
    } state_e;

    state_e                    r_state;
    logic [CntW-1:0]           r_count;
    logic [MaxOutstanding-1:0] r_owner;   // bit 0 is the oldest outstanding owner
    logic                      r_last;

    logic                      w_can_issue;
    logic                      w_sel_valid;
    logic                      w_sel;
    logic [31:0]               w_sel_addr;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_head;
    logic [CntW-1:0]           w_push_idx;
    logic [MaxOutstanding-1:0] w_owner_next;

    assign w_can_issue = (r_count < CntW'(MaxOutstanding));

    // Requester selection; a locked requester owns the bus until granted
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel       = 1'b0;
        case (r_state)
            LOCK0: begin
                w_sel_valid = 1'b1;
                w_sel       = 1'b0;
            end
            LOCK1: begin
                w_sel_valid = 1'b1;
                w_sel       = 1'b1;
            end
            default: begin
                w_sel_valid = w_can_issue && (r0_req_i || r1_req_i);
                if (r0_req_i && r1_req_i) begin
                    w_sel = RoundRobin ? ~r_last : 1'b0;
                end else begin
                    w_sel = r1_req_i;
                end
            end
        endcase
        if (rst_i) begin
            w_sel_valid = 1'b0;
        end
    end

    assign w_sel_addr   = w_sel ? r1_addr_i : r0_addr_i;
    assign instr_req_o  = w_sel_valid;
    assign instr_addr_o = w_sel_valid ? (w_sel_addr & 32'hFFFF_FFFC) : 32'h0;

    assign w_push   = w_sel_valid && instr_gnt_i;
    assign r0_gnt_o = w_push && !w_sel;
    assign r1_gnt_o = w_push && w_sel;

    assign w_head      = r_owner[0];
    assign w_pop       = !rst_i && instr_rvalid_i && (r_count != '0);
    assign r0_rvalid_o = w_pop && !w_head;
    assign r1_rvalid_o = w_pop && w_head;
    assign r0_err_o    = r0_rvalid_o && instr_err_i;
    assign r1_err_o    = r1_rvalid_o && instr_err_i;
    assign spurious_o  = !rst_i && instr_rvalid_i && (r_count == '0);
    assign busy_o      = !rst_i && ((r_count != '0) || w_sel_valid);
    assign rdata_o     = instr_rdata_i;

    // Owner queue as a shift register: pop shifts down, push lands after the last valid entry
    always_comb begin
        w_owner_next = w_pop ? (r_owner >> 1) : r_owner;
        w_push_idx   = w_pop ? (r_count - CntW'(1)) : r_count;
        if (w_push) begin
            for (int unsigned i = 0; i < MaxOutstanding; i++) begin
                if (w_push_idx == CntW'(i)) begin
                    w_owner_next[i] = w_sel;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_count <= '0;
            r_owner <= '0;
            r_last  <= 1'b1;
        end else begin
            r_owner <= w_owner_next;
            if (w_push && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CntW'(1);
            end
            if (w_push) begin
                r_last <= w_sel;
            end
            case (r_state)
                IDLE: begin
                    if (w_sel_valid && !instr_gnt_i) begin
                        r_state <= w_sel ? LOCK1 : LOCK0;
                    end
                end
                default: begin
                    if (instr_gnt_i) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_instr_bus_arbiter.sv
// Directed bench for ibex_instr_bus_arbiter: a round-robin, depth-2 instance and a
// fixed-priority, depth-4 instance share one stimulus stream.
module tb_ibex_instr_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_req = 1'b0, r1_req = 1'b0;
    logic [31:0] r0_addr = '0, r1_addr = '0;
    logic        gnt = 1'b0, rvalid = 1'b0, err = 1'b0;
    logic [31:0] rdata = '0;

    logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
    logic [31:0] rdata_o, instr_addr;
    logic        instr_req, busy, spurious;

    logic        fp_r0_gnt, fp_r0_rvalid, fp_r0_err, fp_r1_gnt, fp_r1_rvalid, fp_r1_err;
    logic [31:0] fp_rdata_o, fp_instr_addr;
    logic        fp_instr_req, fp_busy, fp_spurious;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ibex_instr_bus_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .r0_req_i(r0_req), .r0_addr_i(r0_addr), .r0_gnt_o(r0_gnt),
        .r0_rvalid_o(r0_rvalid), .r0_err_o(r0_err),
        .r1_req_i(r1_req), .r1_addr_i(r1_addr), .r1_gnt_o(r1_gnt),
        .r1_rvalid_o(r1_rvalid), .r1_err_o(r1_err),
        .rdata_o(rdata_o),
        .instr_req_o(instr_req), .instr_addr_o(instr_addr), .instr_gnt_i(gnt),
        .instr_rvalid_i(rvalid), .instr_rdata_i(rdata), .instr_err_i(err),
        .busy_o(busy), .spurious_o(spurious)
    );

    ibex_instr_bus_arbiter #(.MaxOutstanding(4), .RoundRobin(1'b0)) dut_fp (
        .clk_i(clk), .rst_i(rst),
        .r0_req_i(r0_req), .r0_addr_i(r0_addr), .r0_gnt_o(fp_r0_gnt),
        .r0_rvalid_o(fp_r0_rvalid), .r0_err_o(fp_r0_err),
        .r1_req_i(r1_req), .r1_addr_i(r1_addr), .r1_gnt_o(fp_r1_gnt),
        .r1_rvalid_o(fp_r1_rvalid), .r1_err_o(fp_r1_err),
        .rdata_o(fp_rdata_o),
        .instr_req_o(fp_instr_req), .instr_addr_o(fp_instr_addr), .instr_gnt_i(gnt),
        .instr_rvalid_i(rvalid), .instr_rdata_i(rdata), .instr_err_i(err),
        .busy_o(fp_busy), .spurious_o(fp_spurious)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic q0, input logic [31:0] a0, input logic q1,
                         input logic [31:0] a1, input logic g, input logic rv, input logic e);
        r0_req = q0; r0_addr = a0; r1_req = q1; r1_addr = a1;
        gnt = g; rvalid = rv; err = e;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset: outputs held low even with live requests and a response on the bus
        drive(1, 32'h100, 1, 32'h300, 1, 1, 1);
        #2;
        check("rst_req", instr_req, 0);
        check("rst_gnt0", r0_gnt, 0);
        check("rst_gnt1", r1_gnt, 0);
        check("rst_rv0", r0_rvalid, 0);
        check("rst_err1", r1_err, 0);
        check("rst_busy", busy, 0);
        check("rst_spur", spurious, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        #2;
        check("post_rst_busy", busy, 0);
        check("post_rst_req", instr_req, 0);
        tick();

        // Single-requester stream, low address bits masked on the bus
        drive(1, 32'h100, 0, 0, 1, 0, 0);
        #2;
        check("s0_gnt", r0_gnt, 1);
        check("s0_addr", instr_addr, 32'h100);
        check("s0_r1gnt", r1_gnt, 0);
        tick();
        drive(1, 32'h104, 0, 0, 1, 1, 0); rdata = 32'hD000_0001;
        #2;
        check("s1_gnt", r0_gnt, 1);
        check("s1_addr", instr_addr, 32'h104);
        check("s1_rv0", r0_rvalid, 1);
        check("s1_rv1", r1_rvalid, 0);
        check("s1_rdata", rdata_o, 32'hD000_0001);
        tick();
        drive(1, 32'h10B, 0, 0, 1, 1, 0);
        #2;
        check("s2_gnt", r0_gnt, 1);
        check("s2_addr_mask", instr_addr, 32'h108);
        check("s2_rv0", r0_rvalid, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        #2;
        check("s3_rv0", r0_rvalid, 1);
        check("s3_busy", busy, 1);
        check("s3_req", instr_req, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        check("s4_busy", busy, 0);
        check("s4_spur", spurious, 0);

        // Lock on stall, including r0 dropping its request while locked
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(k < 2, 32'h200, 1, 32'h300, 0, 0, 0);
            #2;
            check("lk_req", instr_req, 1);
            check("lk_addr", instr_addr, 32'h200);
            check("lk_gnt0", r0_gnt, 0);
            check("lk_gnt1", r1_gnt, 0);
            tick();
        end
        drive(0, 32'h200, 1, 32'h300, 1, 0, 0);
        #2;
        check("lk_addr_g", instr_addr, 32'h200);
        check("lk_gnt0_g", r0_gnt, 1);
        check("lk_gnt1_g", r1_gnt, 0);
        tick();
        drive(0, 0, 1, 32'h300, 1, 0, 0);
        #2;
        check("lk_r1_addr", instr_addr, 32'h300);
        check("lk_r1_gnt", r1_gnt, 1);
        check("lk_r1_gnt0", r0_gnt, 0);
        tick();

        // Responses in issue order, error on the r1-owned one, then a spurious response
        drive(0, 0, 0, 0, 0, 1, 0); rdata = 32'hAAAA_5555;
        #2;
        check("er_rv0", r0_rvalid, 1);
        check("er_err0", r0_err, 0);
        check("er_rv1", r1_rvalid, 0);
        check("er_rdata", rdata_o, 32'hAAAA_5555);
        tick();
        drive(0, 0, 0, 0, 0, 1, 1);
        #2;
        check("er_rv1b", r1_rvalid, 1);
        check("er_err1b", r1_err, 1);
        check("er_rv0b", r0_rvalid, 0);
        check("er_err0b", r0_err, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        #2;
        check("sp_spur", spurious, 1);
        check("sp_rv0", r0_rvalid, 0);
        check("sp_rv1", r1_rvalid, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        check("sp_spur_end", spurious, 0);
        check("sp_busy", busy, 0);

        // Round robin vs fixed priority under continuous contention
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1, 32'h1000, 1, 32'h2000, 1, k > 0, 0);
            #2;
            check("rr_gnt0", r0_gnt, 32'((k % 2) == 0));
            check("rr_gnt1", r1_gnt, 32'((k % 2) == 1));
            check("rr_addr", instr_addr, ((k % 2) == 0) ? 32'h1000 : 32'h2000);
            check("fp_gnt0", fp_r0_gnt, 1);
            check("fp_gnt1", fp_r1_gnt, 0);
            if (k > 0) begin
                check("rr_rv0", r0_rvalid, 32'((k % 2) == 1));
                check("rr_rv1", r1_rvalid, 32'((k % 2) == 0));
            end
            tick();
        end

        // Outstanding limit: a third request waits for a response, even one in the same cycle
        do_reset();
        drive(1, 32'h400, 0, 0, 1, 0, 0);
        #2;
        check("ol_g0", r0_gnt, 1);
        tick();
        drive(0, 0, 1, 32'h500, 1, 0, 0);
        #2;
        check("ol_g1", r1_gnt, 1);
        tick();
        drive(1, 32'h600, 0, 0, 1, 1, 0);
        #2;
        check("ol_full_req", instr_req, 0);
        check("ol_full_gnt", r0_gnt, 0);
        check("ol_full_rv0", r0_rvalid, 1);
        check("ol_full_busy", busy, 1);
        tick();
        drive(1, 32'h600, 0, 0, 1, 0, 0);
        #2;
        check("ol_third_req", instr_req, 1);
        check("ol_third_gnt", r0_gnt, 1);
        check("ol_third_addr", instr_addr, 32'h600);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        #2;
        check("ol_rv_a1", r1_rvalid, 1);
        check("ol_rv_a0", r0_rvalid, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        #2;
        check("ol_rv_b0", r0_rvalid, 1);
        check("ol_rv_b1", r1_rvalid, 0);
        tick();

        // Async reset with two outstanding and the depth-4 instance locked on r1
        do_reset();
        drive(1, 32'h700, 0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 1, 32'h800, 1, 0, 0);
        tick();
        drive(0, 0, 1, 32'h900, 0, 0, 0);
        #2;
        check("ar_fp_req", fp_instr_req, 1);
        check("ar_fp_addr", fp_instr_addr, 32'h900);
        check("ar_full_req", instr_req, 0);
        tick();
        #1;
        rst = 1'b1;
        #1;
        gnt = 1'b1; rvalid = 1'b1;
        #1;
        check("ar_fp_req0", fp_instr_req, 0);
        check("ar_fp_gnt1", fp_r1_gnt, 0);
        check("ar_fp_busy", fp_busy, 0);
        check("ar_fp_rv1", fp_r1_rvalid, 0);
        check("ar_fp_spur", fp_spurious, 0);
        check("ar_busy", busy, 0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 2; k++) begin
            #2;
            check("ar_spur_fp", fp_spurious, 1);
            check("ar_spur", spurious, 1);
            check("ar_fp_rv0", fp_r0_rvalid, 0);
            check("ar_fp_rv1b", fp_r1_rvalid, 0);
            tick();
        end
        drive(0, 0, 1, 32'hA00, 1, 0, 0);
        #2;
        check("ar_new_gnt_fp", fp_r1_gnt, 1);
        check("ar_new_gnt", r1_gnt, 1);
        check("ar_new_addr", instr_addr, 32'hA00);
        check("ar_new_spur", spurious, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
